// File: rtl/vga_text_pkg.sv
// Shared types and constants for the VGA text overlay path (8x16 font ROM).
package vga_text_pkg;

  localparam int FONT_W = 8;
  localparam int FONT_H = 16;
  localparam int ROM_AW = 11;

  typedef enum logic [1:0] {
    BM_STATIC,
    BM_BLINK,
    BM_SCROLL,
    BM_BLINK_SCROLL
  } banner_mode_t;

  localparam logic [6:0] ASCII_BLANK = 7'h00;

  function automatic logic mode_blinks(input banner_mode_t m);
    return (m == BM_BLINK) || (m == BM_BLINK_SCROLL);
  endfunction

  function automatic logic mode_scrolls(input banner_mode_t m);
    return (m == BM_SCROLL) || (m == BM_BLINK_SCROLL);
  endfunction

endpackage

// File: rtl/banner_anim_ctrl.sv
// Banner animation state: blink/scroll frame counters, mode-change clear, length clamp.
// Updates one cycle after frame_tick/len_we/mode change; no backpressure.
module banner_anim_ctrl
  import vga_text_pkg::*;
#(
  parameter int MAX_CHARS     = 16,
  parameter int BLINK_FRAMES  = 30,
  parameter int SCROLL_FRAMES = 15,
  parameter int CW            = $clog2(MAX_CHARS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic          frame_tick,
  input  logic          len_we,
  input  logic [CW:0]   len_val,
  output logic [CW:0]   msg_len,
  output logic [CW:0]   scroll_off,
  output logic          blink_vis
);

  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam int SW = $clog2(SCROLL_FRAMES + 1);
  localparam logic [CW:0]   MAX_LEN     = (CW+1)'(MAX_CHARS);
  localparam logic [CW:0]   LEN_ONE     = (CW+1)'(1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_FRAMES - 1);
  localparam logic [SW-1:0] SCROLL_LAST = SW'(SCROLL_FRAMES - 1);

  banner_mode_t  cur_mode, mode_q;
  logic          mode_chg;
  logic [CW:0]   len_clamp, msg_len_nxt, scroll_off_nxt;
  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic [SW-1:0] scroll_cnt, scroll_cnt_nxt;
  logic          blink_vis_nxt;

  assign cur_mode  = banner_mode_t'(mode);
  assign mode_chg  = (cur_mode != mode_q);
  assign len_clamp = (len_val > MAX_LEN) ? MAX_LEN : len_val;

  always_comb begin
    blink_cnt_nxt  = blink_cnt;
    blink_vis_nxt  = blink_vis;
    scroll_cnt_nxt = scroll_cnt;
    scroll_off_nxt = scroll_off;
    msg_len_nxt    = len_we ? len_clamp : msg_len;

    if (mode_chg) begin
      blink_cnt_nxt  = '0;
      blink_vis_nxt  = 1'b1;
      scroll_cnt_nxt = '0;
      scroll_off_nxt = '0;
    end else begin
      if (!mode_blinks(cur_mode)) begin
        blink_cnt_nxt = '0;
        blink_vis_nxt = 1'b1;
      end else if (frame_tick) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt_nxt = '0;
          blink_vis_nxt = ~blink_vis;
        end else begin
          blink_cnt_nxt = blink_cnt + BW'(1);
        end
      end

      if (!mode_scrolls(cur_mode)) begin
        scroll_cnt_nxt = '0;
        scroll_off_nxt = '0;
      end else if (len_we) begin
        // A length load suppresses the offset step; the offset is only re-validated.
        if (frame_tick)
          scroll_cnt_nxt = (scroll_cnt == SCROLL_LAST) ? '0 : scroll_cnt + SW'(1);
        if (scroll_off >= len_clamp)
          scroll_off_nxt = '0;
      end else if (frame_tick) begin
        if (scroll_cnt == SCROLL_LAST) begin
          scroll_cnt_nxt = '0;
          scroll_off_nxt = ((msg_len == '0) || (scroll_off >= msg_len - LEN_ONE))
                           ? '0 : scroll_off + LEN_ONE;
        end else begin
          scroll_cnt_nxt = scroll_cnt + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= BM_STATIC;
      msg_len    <= '0;
      blink_cnt  <= '0;
      blink_vis  <= 1'b1;
      scroll_cnt <= '0;
      scroll_off <= '0;
    end else begin
      mode_q     <= cur_mode;
      msg_len    <= msg_len_nxt;
      blink_cnt  <= blink_cnt_nxt;
      blink_vis  <= blink_vis_nxt;
      scroll_cnt <= scroll_cnt_nxt;
      scroll_off <= scroll_off_nxt;
    end
  end

endmodule

// File: rtl/draw_text_banner.sv
// Scaled text banner overlay: string buffer, geometry, font ROM addressing, pixel pipeline.
// pixel_on/text_on lag pix_x/pix_y by ROM_LAT+2 cycles; no backpressure.
module draw_text_banner
  import vga_text_pkg::*;
#(
  parameter int MAX_CHARS     = 16,
  parameter int SCALE_LOG2    = 3,
  parameter int ROM_LAT       = 1,
  parameter int BLINK_FRAMES  = 30,
  parameter int SCROLL_FRAMES = 15,
  localparam int CW           = $clog2(MAX_CHARS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              frame_tick,
  input  logic [9:0]        org_x,
  input  logic [9:0]        org_y,
  input  logic [1:0]        mode,
  input  logic              wr_en,
  input  logic [CW-1:0]     wr_idx,
  input  logic [6:0]        wr_char,
  input  logic              len_we,
  input  logic [CW:0]       len_val,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              text_on,
  output logic              pixel_on
);

  localparam logic [CW:0]   MAX_LEN  = (CW+1)'(MAX_CHARS);
  localparam logic [10:0]   CELL_H   = 11'(FONT_H << SCALE_LOG2);
  localparam int            COL_SH   = SCALE_LOG2 + $clog2(FONT_W);

  logic [6:0]  char_buf [MAX_CHARS];
  logic [CW:0] msg_len, scroll_off, idx;
  logic        blink_vis;
  logic [9:0]  dx, dy, col;
  logic [CW+1:0] sum;
  logic        in_region;
  logic [3:0]  row;
  logic [2:0]  bit_sel;
  logic [6:0]  char_sel;

  logic        on_pipe  [0:ROM_LAT];
  logic [2:0]  bit_pipe [0:ROM_LAT];

  banner_anim_ctrl #(
    .MAX_CHARS    (MAX_CHARS),
    .BLINK_FRAMES (BLINK_FRAMES),
    .SCROLL_FRAMES(SCROLL_FRAMES),
    .CW           (CW)
  ) u_anim (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .frame_tick(frame_tick),
    .len_we    (len_we),
    .len_val   (len_val),
    .msg_len   (msg_len),
    .scroll_off(scroll_off),
    .blink_vis (blink_vis)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_CHARS; i++) char_buf[i] <= ASCII_BLANK;
    end else if (wr_en && ({1'b0, wr_idx} < MAX_LEN)) begin
      char_buf[wr_idx] <= wr_char;
    end
  end

  // Stage 0: geometry and character lookup. Both operands of the wrap are below
  // msg_len whenever in_region holds, so a single subtract is enough.
  always_comb begin
    dx        = pix_x - org_x;
    dy        = pix_y - org_y;
    col       = dx >> COL_SH;
    in_region = enable && (pix_x >= org_x) && (pix_y >= org_y) &&
                ({1'b0, dy} < CELL_H) && (col < 10'(msg_len));
    row       = dy[SCALE_LOG2 +: 4];
    bit_sel   = dx[SCALE_LOG2 +: 3];
    sum       = (CW+2)'(col[CW:0]) + (CW+2)'(scroll_off);
    if (msg_len == '0)
      idx = '0;
    else if (sum >= (CW+2)'(msg_len))
      idx = (CW+1)'(sum - (CW+2)'(msg_len));
    else
      idx = (CW+1)'(sum);
    char_sel = (idx < MAX_LEN) ? char_buf[idx[CW-1:0]] : ASCII_BLANK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
      for (int k = 0; k <= ROM_LAT; k++) begin
        on_pipe[k]  <= 1'b0;
        bit_pipe[k] <= 3'd0;
      end
      text_on  <= 1'b0;
      pixel_on <= 1'b0;
    end else begin
      rom_addr    <= {char_sel, row};
      on_pipe[0]  <= in_region & blink_vis;
      bit_pipe[0] <= bit_sel;
      for (int k = 1; k <= ROM_LAT; k++) begin
        on_pipe[k]  <= on_pipe[k-1];
        bit_pipe[k] <= bit_pipe[k-1];
      end
      text_on  <= on_pipe[ROM_LAT];
      pixel_on <= on_pipe[ROM_LAT] & rom_data[3'd7 - bit_pipe[ROM_LAT]];
    end
  end

endmodule

// File: tb/tb_draw_text_banner.sv
// Scoreboard bench for draw_text_banner with a 1-cycle font ROM model.
module tb_draw_text_banner;
  import vga_text_pkg::*;

  localparam int MAXC = 12;
  localparam int CW   = 4;
  localparam int LAT  = 3;

  logic        clk, rst, enable, frame_tick, wr_en, len_we;
  logic [9:0]  pix_x, pix_y, org_x, org_y;
  logic [1:0]  mode;
  logic [CW-1:0] wr_idx;
  logic [6:0]  wr_char;
  logic [CW:0] len_val;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        text_on, pixel_on;

  draw_text_banner #(.MAX_CHARS(MAXC), .SCALE_LOG2(3), .ROM_LAT(1),
                     .BLINK_FRAMES(30), .SCROLL_FRAMES(15)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pix_x(pix_x), .pix_y(pix_y),
    .frame_tick(frame_tick), .org_x(org_x), .org_y(org_y), .mode(mode),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_char(wr_char), .len_we(len_we),
    .len_val(len_val), .rom_addr(rom_addr), .rom_data(rom_data),
    .text_on(text_on), .pixel_on(pixel_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] font_row(input logic [10:0] a);
    if (a[10:4] == 7'h46) return 8'h80;
    return {a[10:4], 1'b0} ^ {a[3:0], a[3:0]};
  endfunction

  always @(posedge clk) rom_data <= font_row(rom_addr);

  int checks = 0, errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference state, updated by the stimulus tasks.
  logic [6:0] m_buf [MAXC];
  int m_len, m_off;
  logic m_vis;

  typedef struct { int due; logic t; logic p; } exp_t;
  exp_t sb[$];
  exp_t cur;

  function automatic void model(input logic [9:0] x, input logic [9:0] y,
                                output logic t, output logic p);
    logic [9:0] ddx, ddy;
    int col, idx, bs;
    logic [7:0] f;
    ddx = x - org_x;
    ddy = y - org_y;
    col = int'(ddx) / 64;
    t = 1'b0;
    p = 1'b0;
    if (enable && x >= org_x && y >= org_y && ddy < 128 && col < m_len) begin
      idx = (col + m_off) % m_len;
      f   = font_row({m_buf[idx], ddy[6:3]});
      bs  = 7 - int'(ddx[5:3]);
      t   = m_vis;
      p   = m_vis & f[bs];
    end
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      cur = sb.pop_front();
      check_eq("text_on", text_on, cur.t);
      check_eq("pixel_on", pixel_on, cur.p);
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic pix(input int x, input int y);
    logic t, p;
    pix_x = 10'(x);
    pix_y = 10'(y);
    model(pix_x, pix_y, t, p);
    sb.push_back('{cyc + LAT, t, p});
    @(posedge clk); #1;
  endtask

  task automatic sweep(input int y, input int x0, input int x1, input int step);
    for (int x = x0; x <= x1; x += step) pix(x, y);
  endtask

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    repeat (n) @(posedge clk);
    #1 frame_tick = 1'b0;
  endtask

  task automatic put_char(input int i, input logic [6:0] c);
    wr_en = 1'b1; wr_idx = CW'(i); wr_char = c;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (i < MAXC) m_buf[i] = c;
  endtask

  task automatic set_len(input int v);
    len_we = 1'b1; len_val = (CW+1)'(v);
    @(posedge clk); #1;
    len_we = 1'b0;
    m_len = (v > MAXC) ? MAXC : v;
    if (m_off >= m_len) m_off = 0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    mode = m;
    @(posedge clk); #1;
    m_off = 0;
    m_vis = 1'b1;
  endtask

  task automatic drain();
    repeat (LAT + 1) @(posedge clk);
    #1 check_eq("drain", sb.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  logic [6:0] finish_str [6];

  initial begin
    finish_str = '{7'h46, 7'h69, 7'h6E, 7'h69, 7'h73, 7'h68};
    rst = 1'b1; enable = 1'b1; frame_tick = 1'b0; wr_en = 1'b0; len_we = 1'b0;
    pix_x = '0; pix_y = '0; org_x = 10'd128; org_y = 10'd128; mode = 2'd0;
    wr_idx = '0; wr_char = '0; len_val = '0;
    for (int i = 0; i < MAXC; i++) m_buf[i] = 7'h00;
    m_len = 0; m_off = 0; m_vis = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rom_addr", rom_addr, 0);
    check_eq("rst_text_on", text_on, 0);
    check_eq("rst_pixel_on", pixel_on, 0);
    rst = 1'b0;

    // Empty message never lights.
    sweep(130, 120, 400, 16);

    for (int i = 0; i < 6; i++) put_char(i, finish_str[i]);
    set_len(6);
    pix(200, 130);
    check_eq("addr_col1", rom_addr, {7'h69, 4'h0});
    pix(127, 130);
    sweep(130, 128, 136, 1);          // bit order on the 'F' row
    pix(130, 255); pix(130, 256);
    for (int y = 128; y < 280; y += 37) sweep(y, 120, 560, 11);
    enable = 1'b0;
    sweep(140, 128, 300, 20);
    enable = 1'b1;
    drain();

    // Blink.
    set_mode(2'd1);
    ticks(29);
    sweep(150, 128, 400, 9);
    ticks(1);  m_vis = 1'b0;
    sweep(150, 128, 400, 9);
    ticks(30); m_vis = 1'b1;
    sweep(150, 128, 400, 9);
    ticks(30); m_vis = 1'b0;
    sweep(150, 128, 400, 9);
    set_mode(2'd0);
    sweep(150, 128, 400, 9);
    drain();

    // Scroll.
    set_mode(2'd2);
    ticks(15); m_off = 1;
    pix(130, 130);
    check_eq("scroll1_col0", rom_addr, {7'h69, 4'h0});
    sweep(170, 120, 520, 13);
    ticks(75); m_off = 0;
    pix(130, 130);
    check_eq("scroll_wrap_col0", rom_addr, {7'h46, 4'h0});
    ticks(60); m_off = 4;
    pix(130, 130);
    check_eq("scroll4_col0", rom_addr, {7'h73, 4'h0});
    sweep(190, 120, 520, 13);
    set_len(2);
    pix(130, 130);
    check_eq("shrink_col0", rom_addr, {7'h46, 4'h0});
    pix(200, 130);
    check_eq("shrink_col1", rom_addr, {7'h69, 4'h0});
    sweep(200, 120, 300, 7);
    drain();

    // Boundaries: out-of-range slot, length clamp.
    set_mode(2'd0);
    put_char(MAXC, 7'h7F);
    put_char(11, 7'h5A);
    set_len(MAXC + 3);
    pix(130, 130);
    check_eq("oob_write_col0", rom_addr, {7'h46, 4'h0});
    pix(835, 130);
    check_eq("clamp_col11", rom_addr, {7'h5A, 4'h0});
    pix(899, 130);
    sweep(210, 120, 1000, 23);
    drain();

    // Asynchronous reset in the middle of a line.
    sweep(130, 128, 200, 3);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_rom_addr", rom_addr, 0);
    check_eq("arst_text_on", text_on, 0);
    check_eq("arst_pixel_on", pixel_on, 0);
    sb.delete();
    for (int i = 0; i < MAXC; i++) m_buf[i] = 7'h00;
    m_len = 0; m_off = 0; m_vis = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    put_char(0, 7'h46);
    put_char(1, 7'h48);
    set_len(2);
    pix(130, 130);
    check_eq("recover_col0", rom_addr, {7'h46, 4'h0});
    sweep(131, 128, 260, 5);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_text_banner.md
Name: draw_text_banner

Overview:
- Parametrised successor to the fixed-string overlay blocks in the VGA text path.
- Renders a runtime-loadable string of up to MAX_CHARS glyphs at a runtime origin, with integer glyph scaling, and static, blink, scroll or blink+scroll modes.
- Drives the shared 8x16 font ROM address and consumes its data.
- Emits a pixel-aligned overlay bit to the colour mux.

Parameters:
- MAX_CHARS, 16, message buffer depth; index width CW = clog2(MAX_CHARS).
- SCALE_LOG2, 3, each font pixel is a (1<<SCALE_LOG2)-square block; cell is (8<<SCALE_LOG2) wide by (16<<SCALE_LOG2) high.
- ROM_LAT, 1, font ROM read latency in cycles (0..3).
- BLINK_FRAMES, 30, frame_tick count per blink half-period.
- SCROLL_FRAMES, 15, frame_tick count per one-character scroll step.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  overlay enable, sampled with the pixel
- pix_x  in  10  current pixel column
- pix_y  in  10  current pixel row
- frame_tick  in  1  one-cycle pulse per frame (vsync edge)
- org_x  in  10  banner left edge
- org_y  in  10  banner top edge
- mode  in  2  0 static, 1 blink, 2 scroll, 3 blink+scroll
- wr_en  in  1  buffer write strobe
- wr_idx  in  CW  buffer slot
- wr_char  in  7  ASCII code
- len_we  in  1  length write strobe
- len_val  in  CW+1  message length (0..MAX_CHARS)
- rom_addr  out  11  {char[6:0], row[3:0]} to the font ROM
- rom_data  in  8  font row; bit 7 is the leftmost pixel
- text_on  out  1  banner region active, aligned with pixel_on
- pixel_on  out  1  glyph pixel lit

Behaviour:
- Reset (async, rst=1): buffer all 7'h00, msg_len=0, blink_cnt=0, blink_vis=1, scroll_cnt=0, scroll_off=0, all pipeline registers 0, so rom_addr=0, text_on=0, pixel_on=0.
- Geometry, computed in stage 0 with unsigned arithmetic:
  - dx = pix_x-org_x, dy = pix_y-org_y.
  - col = dx>>(SCALE_LOG2+3).
  - in_region = enable & pix_x>=org_x & pix_y>=org_y & dy<(16<<SCALE_LOG2) & col<msg_len.
  - row = (dy>>SCALE_LOG2)[3:0], bit = (dx>>SCALE_LOG2)[2:0].
- Character selection:
  - idx = (col+scroll_off) mod msg_len.
  - The wrap is a compare-and-subtract; because col<msg_len and scroll_off<msg_len, one subtraction suffices.
  - char = buf[idx].
- Pipeline:
  - Cycle 1: rom_addr={char,row} is registered. Stage 1 carries on=in_region&blink_vis and bit.
  - Delay stages: on and bit are delayed ROM_LAT further cycles.
  - Cycle ROM_LAT+2: text_on=on_d and pixel_on=on_d & rom_data[7-bit_d] are registered.
  - Total latency from pix_x/pix_y to pixel_on is ROM_LAT+2 cycles; the caller delays sync signals to match.
- Blink counter (modes 1, 3):
  - On frame_tick, blink_cnt increments.
  - When blink_cnt reaches BLINK_FRAMES-1, blink_cnt goes to 0 and blink_vis toggles.
  - In modes 0 and 2, blink_vis is held at 1 and blink_cnt at 0.
- Scroll counter (modes 2, 3):
  - On frame_tick, scroll_cnt increments.
  - When scroll_cnt reaches SCROLL_FRAMES-1, scroll_cnt goes to 0 and scroll_off advances by 1, wrapping to 0 at msg_len-1.
  - In modes 0 and 1, scroll_cnt and scroll_off are held at 0.
- Mode change: any change of mode (registered compare) clears blink_cnt, scroll_cnt and scroll_off, and sets blink_vis=1 on the next cycle.
- Buffer writes:
  - wr_en writes buf[wr_idx]=wr_char at the clock edge.
  - wr_idx>=MAX_CHARS is ignored.
  - The new glyph is visible from the next pixel; no frame synchronisation.
- Length writes:
  - len_we loads msg_len = min(len_val, MAX_CHARS).
  - If scroll_off>=new length, scroll_off is cleared to 0 in the same cycle.
- Simultaneous events:
  - len_we with frame_tick: length load wins and scroll_off is recomputed against the new length, with no advance.
  - wr_en with len_we: both take effect.
  - Mode change with frame_tick: the clear wins.
- msg_len=0: in_region is 0 everywhere and the scroll arithmetic is bypassed (idx=0).
- Origin: org_x/org_y are sampled per pixel; the banner clips at the 10-bit wrap (dx underflow is rejected by the pix_x>=org_x check).
- Reset mid-frame: outputs drop to 0 asynchronously; recovery needs only the pipeline refill of ROM_LAT+2 cycles.

Decomposition:
- Shared package vga_text_pkg:
  - FONT_W=8, FONT_H=16, ROM_AW=11.
  - Mode enum banner_mode_t {BM_STATIC, BM_BLINK, BM_SCROLL, BM_BLINK_SCROLL}.
  - ASCII constant for blank (7'h00).
- Sub-module banner_anim_ctrl (blink and scroll counters, mode-change clear, length clamp).
- Geometry, buffer and pipeline stay in the top level.

Test Plan:
- Static, ROM_LAT=1, SCALE_LOG2=3, org=(128,128), load "Finish", len=6, pix=(200,130) -> rom_addr={7'h69,4'h0} at cycle 1, text_on=1 at cycle 3; pix=(127,130) -> text_on=0.
- Glyph bit order: rom_data=8'b1000_0000 for the addressed row, pix_x=org_x..org_x+7 -> pixel_on=1; pix_x=org_x+8 -> pixel_on=0.
- Blink, BLINK_FRAMES=30: 30 frame_ticks -> text_on=0 over the banner; 30 more -> text_on=1; switch to static mid-off -> visible the next cycle.
- Scroll, len=6, SCROLL_FRAMES=15: 15 ticks -> column 0 shows buf[1]; after 90 ticks scroll_off=0 again; len_we to 2 while scroll_off=4 -> scroll_off=0.
- Boundaries: len=0 -> text_on never asserts; wr_idx=MAX_CHARS ignored (read back unchanged); len_val=MAX_CHARS+3 -> msg_len=MAX_CHARS.
- Async reset asserted mid-line -> rom_addr, text_on and pixel_on read 0 within the same cycle; after release, correct output ROM_LAT+2 cycles after the first pixel.
